mem_port_ctrl: RTL and testbench

Single-port memory access controller for the pipelined RISC-V core: the initiator side of the unified instruction/data memory. Arbitrates instruction-fetch and load/store requests onto the one memory port. Drives the memory command signals (read/write/func/address/write data) and captures returned read data. Returns fetched instructions with byte-swapping, and load results sign/zero-extended per funct3.

---
 rtl/mem_port_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 562 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-port memory initiator arbitrating instruction fetch and
// load/store traffic, with a fixed two-cycle request-to-response latency.
module mem_port_ctrl #(
  parameter int unsigned DATA_BASE   = 255,
  parameter int unsigned MEM_AW      = 9,
  parameter int unsigned MAX_DSTREAK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq_valid,
  input  logic [MEM_AW-1:0] ireq_addr,
  output logic              ireq_ready,
  input  logic              dreq_valid,
  input  logic              dreq_we,
  input  logic [2:0]        dreq_funct3,
  input  logic [5:0]        dreq_addr,
  input  logic [31:0]       dreq_wdata,
  output logic              dreq_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              dresp_valid,
  output logic [31:0]       dresp_rdata,
  output logic              dresp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 2);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [SW-1:0]     streak_q, streak_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_fetch_q, cmd_fetch_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_err_q, cmd_err_d;
  logic [2:0]        cmd_funct3_q, cmd_funct3_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        mem_func_q, mem_func_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              dresp_valid_q, dresp_valid_d;
  logic [31:0]       dresp_rdata_q, dresp_rdata_d;
  logic              dresp_err_q, dresp_err_d;

  logic              fetch_prio_c;
  logic              igrant_c, dgrant_c;
  logic              d_illegal_c, d_misalign_c, d_err_c;
  logic [MEM_AW-1:0] d_addr_c;

  // Arbitration: data first, unless a waiting fetch has seen MAX_DSTREAK data grants.
  always_comb begin
    fetch_prio_c = ireq_valid && (streak_q == SW'(MAX_DSTREAK));
    dgrant_c     = rst && dreq_valid && !fetch_prio_c;
    igrant_c     = rst && ireq_valid && !dgrant_c;
    streak_d     = streak_q;
    if (!ireq_valid || igrant_c) begin
      streak_d = '0;
    end else if (dgrant_c) begin
      streak_d = streak_q + SW'(1);
    end
  end

  assign ireq_ready = igrant_c;
  assign dreq_ready = dgrant_c;

  // Data request decode; alignment is judged on the offset, not the physical address.
  always_comb begin
    if (dreq_we) begin
      d_illegal_c = dreq_funct3[2] || (dreq_funct3[1:0] == 2'b11);
    end else begin
      d_illegal_c = (dreq_funct3[1:0] == 2'b11) || (dreq_funct3 == 3'b110);
    end
    d_misalign_c = ((dreq_funct3[1:0] == 2'b01) && dreq_addr[0]) ||
                   ((dreq_funct3[1:0] == 2'b10) && (dreq_addr[1:0] != 2'b00));
    d_err_c      = d_illegal_c || d_misalign_c;
    d_addr_c     = MEM_AW'(dreq_addr) + MEM_AW'(DATA_BASE);
  end

  // Command stage: the accepted request drives the memory port for one cycle.
  always_comb begin
    cmd_valid_d  = igrant_c || dgrant_c;
    cmd_fetch_d  = igrant_c;
    cmd_we_d     = dgrant_c && dreq_we;
    cmd_funct3_d = dgrant_c ? dreq_funct3 : F3_W;
    cmd_err_d    = dgrant_c && d_err_c;
    mem_read_d   = igrant_c || (dgrant_c && !dreq_we && !d_err_c);
    mem_write_d  = dgrant_c && dreq_we && !d_err_c;
    mem_func_d   = mem_func_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (igrant_c) begin
      mem_func_d = 3'b010;
      mem_addr_d = ireq_addr;
    end else if (dgrant_c) begin
      mem_func_d  = dreq_we ? {1'b0, dreq_funct3[1:0]} : 3'b010;
      mem_addr_d  = d_addr_c;
      mem_wdata_d = dreq_wdata;
    end
  end

  // Response stage: byte-swap fetches, extend loads, acknowledge stores and errors.
  always_comb begin
    instr_valid_d = cmd_valid_q && cmd_fetch_q;
    dresp_valid_d = cmd_valid_q && !cmd_fetch_q;
    dresp_err_d   = cmd_valid_q && !cmd_fetch_q && cmd_err_q;
    instr_d       = instr_q;
    dresp_rdata_d = dresp_rdata_q;
    if (instr_valid_d) begin
      instr_d = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
    end
    if (dresp_valid_d) begin
      dresp_rdata_d = '0;
      if (!cmd_we_q && !cmd_err_q) begin
        unique case (cmd_funct3_q)
          F3_B:    dresp_rdata_d = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
          F3_BU:   dresp_rdata_d = {24'd0, mem_rdata[31:24]};
          F3_H:    dresp_rdata_d = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
          F3_HU:   dresp_rdata_d = {16'd0, mem_rdata[31:16]};
          F3_W:    dresp_rdata_d = mem_rdata;
          default: dresp_rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_fetch_q   <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      cmd_funct3_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_func_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      dresp_valid_q <= 1'b0;
      dresp_rdata_q <= '0;
      dresp_err_q   <= 1'b0;
    end else begin
      streak_q      <= streak_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_fetch_q   <= cmd_fetch_d;
      cmd_we_q      <= cmd_we_d;
      cmd_err_q     <= cmd_err_d;
      cmd_funct3_q  <= cmd_funct3_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_func_q    <= mem_func_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      dresp_valid_q <= dresp_valid_d;
      dresp_rdata_q <= dresp_rdata_d;
      dresp_err_q   <= dresp_err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_func    = mem_func_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign dresp_valid = dresp_valid_q;
  assign dresp_rdata = dresp_rdata_q;
  assign dresp_err   = dresp_err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed scenarios plus a randomized run scored against a
// cycle-level reference model of arbitration, memory contents and responses.
module tb_mem_port_ctrl;

  localparam int unsigned DATA_BASE   = 255;
  localparam int unsigned MEM_AW      = 9;
  localparam int unsigned MAX_DSTREAK = 2;
  localparam int          MEM_BYTES   = 512;

  logic              clk;
  logic              rst;
  logic              ireq_valid;
  logic [MEM_AW-1:0] ireq_addr;
  logic              ireq_ready;
  logic              dreq_valid;
  logic              dreq_we;
  logic [2:0]        dreq_funct3;
  logic [5:0]        dreq_addr;
  logic [31:0]       dreq_wdata;
  logic              dreq_ready;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              dresp_valid;
  logic [31:0]       dresp_rdata;
  logic              dresp_err;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int vectors;
  int miscompares;

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  typedef struct {
    bit          v;
    bit          fetch;
    bit          we;
    bit          err;
    logic [2:0]  f3;
    logic [5:0]  off;
    logic [8:0]  addr;
    logic [31:0] wd;
  } cmd_t;

  mem_port_ctrl #(
    .DATA_BASE  (DATA_BASE),
    .MEM_AW     (MEM_AW),
    .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ireq_valid (ireq_valid),
    .ireq_addr  (ireq_addr),
    .ireq_ready (ireq_ready),
    .dreq_valid (dreq_valid),
    .dreq_we    (dreq_we),
    .dreq_funct3(dreq_funct3),
    .dreq_addr  (dreq_addr),
    .dreq_wdata (dreq_wdata),
    .dreq_ready (dreq_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .dresp_valid(dresp_valid),
    .dresp_rdata(dresp_rdata),
    .dresp_err  (dresp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_func   (mem_func),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap(int a);
    return a % MEM_BYTES;
  endfunction

  function automatic logic [7:0] init_byte(int i);
    case (i)
      0:       return 8'h17;
      1:       return 8'h31;
      2, 3:    return 8'h00;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Big-endian byte memory on the DUT's port; stores commit at the clock edge.
  assign mem_rdata = {mem[mem_addr], mem[9'(mem_addr + 9'd1)],
                      mem[9'(mem_addr + 9'd2)], mem[9'(mem_addr + 9'd3)]};

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_write) begin
        case (mem_func)
          3'b000: mem[mem_addr] <= mem_wdata[7:0];
          3'b001: begin
            mem[mem_addr]              <= mem_wdata[15:8];
            mem[9'(mem_addr + 9'd1)]   <= mem_wdata[7:0];
          end
          default: begin
            mem[mem_addr]              <= mem_wdata[31:24];
            mem[9'(mem_addr + 9'd1)]   <= mem_wdata[23:16];
            mem[9'(mem_addr + 9'd2)]   <= mem_wdata[15:8];
            mem[9'(mem_addr + 9'd3)]   <= mem_wdata[7:0];
          end
        endcase
      end
    end
  end

  // Reference model helpers, in terms of bytes and integer arithmetic.
  function automatic logic [31:0] ref_instr(int a);
    return {ref_mem[wrap(a + 3)], ref_mem[wrap(a + 2)], ref_mem[wrap(a + 1)], ref_mem[wrap(a)]};
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [5:0] off);
    int p = int'(off) + int'(DATA_BASE);
    int b0 = int'(ref_mem[wrap(p)]);
    int b1 = int'(ref_mem[wrap(p + 1)]);
    int v;
    case (f3)
      3'b000:  v = (b0 >= 128) ? b0 - 256 : b0;
      3'b100:  v = b0;
      3'b001:  v = (b0 * 256 + b1 >= 32768) ? b0 * 256 + b1 - 65536 : b0 * 256 + b1;
      3'b101:  v = b0 * 256 + b1;
      3'b010:  return {ref_mem[wrap(p)], ref_mem[wrap(p + 1)], ref_mem[wrap(p + 2)], ref_mem[wrap(p + 3)]};
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic void ref_store(logic [2:0] f3, logic [5:0] off, logic [31:0] wd);
    int p = int'(off) + int'(DATA_BASE);
    int n = 1 << int'(f3[1:0]);
    for (int k = 0; k < n; k++) ref_mem[wrap(p + k)] = 8'(wd >> (8 * (n - 1 - k)));
  endfunction

  function automatic bit ref_err(bit we, logic [2:0] f3, logic [5:0] off);
    bit legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    int n = 1 << int'(f3[1:0]);
    return !legal || ((int'(off) % n) != 0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_we     = 1'b0;
    dreq_funct3 = '0;
    dreq_addr   = '0;
    dreq_wdata  = '0;
  endtask

  task automatic drive_fetch(input logic [8:0] a);
    drive_idle();
    ireq_valid = 1'b1;
    ireq_addr  = a;
  endtask

  task automatic drive_data(input bit we, input logic [2:0] f3, input logic [5:0] off,
                            input logic [31:0] wd);
    drive_idle();
    dreq_valid  = 1'b1;
    dreq_we     = we;
    dreq_funct3 = f3;
    dreq_addr   = off;
    dreq_wdata  = wd;
  endtask

  task automatic test_reset;
    ireq_valid = 1'b1;
    dreq_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ireq_ready, dreq_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 00", {ireq_ready, dreq_ready});
    end
    vectors++;
    if ({mem_read, mem_write, instr_valid, dresp_valid, dresp_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {mem_read, mem_write, instr_valid, dresp_valid, dresp_err});
    end
    vectors++;
    if (instr !== 32'd0 || dresp_rdata !== 32'd0 || mem_addr !== 9'd0 ||
        mem_wdata !== 32'd0 || mem_func !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data: instr=%h rdata=%h addr=%h wdata=%h func=%h expected all 0",
               instr, dresp_rdata, mem_addr, mem_wdata, mem_func);
    end
    drive_idle();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch;
    drive_fetch(9'd0);
    @(negedge clk);
    vectors++;
    if ({ireq_ready, dreq_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL fetch_ready: got %b expected 10", {ireq_ready, dreq_ready});
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 9'd0 || mem_func !== 3'b010) begin
      miscompares++;
      $display("FAIL fetch_cmd: rd=%b wr=%b addr=%h func=%b expected 1 0 000 010",
               mem_read, mem_write, mem_addr, mem_func);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || dresp_valid !== 1'b0 || instr !== 32'h0000_3117) begin
      miscompares++;
      $display("FAIL fetch_resp: iv=%b dv=%b instr=%h expected 1 0 00003117",
               instr_valid, dresp_valid, instr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse: instr_valid=%b expected 0", instr_valid);
    end
  endtask

  task automatic test_store_load;
    drive_data(1'b1, 3'b000, 6'd0, 32'hABCD_12F0);
    @(negedge clk);
    vectors++;
    if ({ireq_ready, dreq_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL sb_ready: got %b expected 01", {ireq_ready, dreq_ready});
    end
    tick();
    drive_data(1'b0, 3'b000, 6'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 9'd255 ||
        mem_func !== 3'b000 || mem_wdata !== 32'hABCD_12F0) begin
      miscompares++;
      $display("FAIL sb_cmd: wr=%b rd=%b addr=%0d func=%b wdata=%h expected 1 0 255 000 abcd12f0",
               mem_write, mem_read, mem_addr, mem_func, mem_wdata);
    end
    ref_store(3'b000, 6'd0, 32'hABCD_12F0);
    tick();
    drive_data(1'b0, 3'b100, 6'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_rdata !== 32'd0 || dresp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_ack: dv=%b rdata=%h err=%b expected 1 0 0", dresp_valid, dresp_rdata, dresp_err);
    end
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 9'd255 || mem_func !== 3'b010) begin
      miscompares++;
      $display("FAIL lb_cmd: rd=%b addr=%0d func=%b expected 1 255 010", mem_read, mem_addr, mem_func);
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_rdata !== 32'hFFFF_FFF0 || dresp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lb_resp: dv=%b rdata=%h err=%b expected 1 fffffff0 0", dresp_valid, dresp_rdata, dresp_err);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_rdata !== 32'h0000_00F0) begin
      miscompares++;
      $display("FAIL lbu_resp: dv=%b rdata=%h expected 1 000000f0", dresp_valid, dresp_rdata);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lbu_pulse: dresp_valid=%b expected 0", dresp_valid);
    end
  endtask

  task automatic test_half;
    drive_data(1'b1, 3'b001, 6'd0, 32'h5555_1919);
    tick();
    drive_data(1'b0, 3'b101, 6'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1 || mem_addr !== 9'd255 || mem_func !== 3'b001) begin
      miscompares++;
      $display("FAIL sh_cmd: wr=%b addr=%0d func=%b expected 1 255 001", mem_write, mem_addr, mem_func);
    end
    ref_store(3'b001, 6'd0, 32'h5555_1919);
    tick();
    drive_data(1'b0, 3'b001, 6'd1, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || dresp_valid !== 1'b1 || dresp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL sh_ack: rd=%b dv=%b rdata=%h expected 1 1 0", mem_read, dresp_valid, dresp_rdata);
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_rdata !== 32'h0000_1919 || dresp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lhu_resp: dv=%b rdata=%h err=%b expected 1 00001919 0", dresp_valid, dresp_rdata, dresp_err);
    end
    vectors++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL lh_odd_cmd: rd=%b wr=%b expected 0 0", mem_read, mem_write);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_err !== 1'b1 || dresp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL lh_odd_resp: dv=%b err=%b rdata=%h expected 1 1 0", dresp_valid, dresp_err, dresp_rdata);
    end
    tick();
  endtask

  task automatic test_errors;
    drive_data(1'b1, 3'b010, 6'd2, 32'hDEAD_BEEF);
    tick();
    drive_data(1'b0, 3'b011, 6'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_mis_cmd: wr=%b rd=%b expected 0 0", mem_write, mem_read);
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_err !== 1'b1 || dresp_rdata !== 32'd0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_mis_resp: dv=%b err=%b rdata=%h rd=%b wr=%b expected 1 1 0 0 0",
               dresp_valid, dresp_err, dresp_rdata, mem_read, mem_write);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (dresp_valid !== 1'b1 || dresp_err !== 1'b1 || dresp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL ld011_resp: dv=%b err=%b rdata=%h expected 1 1 0", dresp_valid, dresp_err, dresp_rdata);
    end
    tick();
  endtask

  task automatic test_arbitration;
    bit is_fetch [6];
    for (int k = 0; k < 6; k++) is_fetch[k] = (k % 3) == 2;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drive_data(1'b0, 3'b010, 6'(4 * k), 32'd0);
        ireq_valid = 1'b1;
        ireq_addr  = 9'h040;
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (k < 6) begin
        vectors++;
        if (ireq_ready !== is_fetch[k] || dreq_ready !== !is_fetch[k]) begin
          miscompares++;
          $display("FAIL arb_grant %0d: got i=%b d=%b expected i=%b d=%b",
                   k, ireq_ready, dreq_ready, is_fetch[k], !is_fetch[k]);
        end
      end
      if (k >= 2) begin
        vectors++;
        if (is_fetch[k-2]) begin
          if (instr_valid !== 1'b1 || dresp_valid !== 1'b0 || instr !== ref_instr(32'h40)) begin
            miscompares++;
            $display("FAIL arb_resp %0d: iv=%b dv=%b instr=%h expected 1 0 %h",
                     k, instr_valid, dresp_valid, instr, ref_instr(32'h40));
          end
        end else begin
          if (dresp_valid !== 1'b1 || instr_valid !== 1'b0 ||
              dresp_rdata !== ref_load(3'b010, 6'(4 * (k - 2)))) begin
            miscompares++;
            $display("FAIL arb_resp %0d: dv=%b iv=%b rdata=%h expected 1 0 %h",
                     k, dresp_valid, instr_valid, dresp_rdata, ref_load(3'b010, 6'(4 * (k - 2))));
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    drive_data(1'b1, 3'b010, 6'd8, 32'h1122_3344);
    tick();
    drive_idle();
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: mem_write=%b expected 1", mem_write);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, dresp_valid, instr_valid, dresp_err, ireq_ready, dreq_ready} !== 7'b0 ||
        mem_addr !== 9'd0 || mem_wdata !== 32'd0 || mem_func !== 3'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: wr=%b rd=%b dv=%b addr=%h wdata=%h func=%b expected all 0",
               mem_write, mem_read, dresp_valid, mem_addr, mem_wdata, mem_func);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (dresp_valid !== 1'b0 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_noresp %0d: dv=%b iv=%b expected 0 0", k, dresp_valid, instr_valid);
      end
    end
    vectors++;
    if (mem[263] !== ref_mem[263] || mem[266] !== ref_mem[266]) begin
      miscompares++;
      $display("FAIL rstmid_nocommit: mem263=%h mem266=%h expected %h %h",
               mem[263], mem[266], ref_mem[263], ref_mem[266]);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    cmd_t        s1, nxt;
    bit          r_iv, r_dv, r_err, gi, gd, exp_rd, exp_wr, pend;
    logic [31:0] r_instr, r_rdata;
    logic [2:0]  exp_func;
    int          streak;
    s1.v = 1'b0; r_iv = 1'b0; r_dv = 1'b0; r_err = 1'b0; pend = 1'b0; streak = 0;
    r_instr = '0; r_rdata = '0;
    for (int c = 0; c < n + 3; c++) begin
      if (c >= n) begin
        drive_idle();
      end else begin
        if (!pend) begin
          ireq_valid = $urandom_range(0, 9) < 6;
          ireq_addr  = 9'($urandom);
        end
        dreq_valid  = $urandom_range(0, 9) < 6;
        dreq_we     = 1'($urandom);
        dreq_funct3 = 3'($urandom);
        dreq_addr   = 6'($urandom);
        if ($urandom_range(0, 1) == 1) dreq_addr[1:0] = 2'b00;
        dreq_wdata  = $urandom;
      end
      @(negedge clk);
      gd = dreq_valid && !(ireq_valid && streak == int'(MAX_DSTREAK));
      gi = ireq_valid && !gd;
      vectors++;
      if (ireq_ready !== gi || dreq_ready !== gd) begin
        miscompares++;
        $display("FAIL rand_ready cyc %0d: got i=%b d=%b expected i=%b d=%b", c, ireq_ready, dreq_ready, gi, gd);
      end
      exp_rd   = s1.v && (s1.fetch || (!s1.we && !s1.err));
      exp_wr   = s1.v && !s1.fetch && s1.we && !s1.err;
      exp_func = (s1.fetch || !s1.we) ? 3'b010 : {1'b0, s1.f3[1:0]};
      vectors++;
      if (mem_read !== exp_rd || mem_write !== exp_wr) begin
        miscompares++;
        $display("FAIL rand_strobe cyc %0d: got rd=%b wr=%b expected rd=%b wr=%b", c, mem_read, mem_write, exp_rd, exp_wr);
      end
      if (exp_rd || exp_wr) begin
        vectors++;
        if (mem_addr !== s1.addr || mem_func !== exp_func || (exp_wr && mem_wdata !== s1.wd)) begin
          miscompares++;
          $display("FAIL rand_cmd cyc %0d: got addr=%h func=%b wdata=%h expected %h %b %h",
                   c, mem_addr, mem_func, mem_wdata, s1.addr, exp_func, s1.wd);
        end
      end
      vectors++;
      if (instr_valid !== r_iv || dresp_valid !== r_dv) begin
        miscompares++;
        $display("FAIL rand_valid cyc %0d: got iv=%b dv=%b expected iv=%b dv=%b", c, instr_valid, dresp_valid, r_iv, r_dv);
      end
      if (r_iv) begin
        vectors++;
        if (instr !== r_instr) begin
          miscompares++;
          $display("FAIL rand_instr cyc %0d: got %h expected %h", c, instr, r_instr);
        end
      end
      if (r_dv) begin
        vectors++;
        if (dresp_rdata !== r_rdata || dresp_err !== r_err) begin
          miscompares++;
          $display("FAIL rand_dresp cyc %0d: got rdata=%h err=%b expected %h %b", c, dresp_rdata, dresp_err, r_rdata, r_err);
        end
      end
      r_iv = s1.v && s1.fetch;
      r_dv = s1.v && !s1.fetch;
      if (r_iv) r_instr = ref_instr(int'(s1.addr));
      if (r_dv) begin
        r_err   = s1.err;
        r_rdata = (s1.err || s1.we) ? 32'd0 : ref_load(s1.f3, s1.off);
        if (s1.we && !s1.err) ref_store(s1.f3, s1.off, s1.wd);
      end
      nxt.v     = gi || gd;
      nxt.fetch = gi;
      nxt.we    = gd && dreq_we;
      nxt.err   = gd && ref_err(dreq_we, dreq_funct3, dreq_addr);
      nxt.f3    = dreq_funct3;
      nxt.off   = dreq_addr;
      nxt.addr  = gi ? ireq_addr : 9'(int'(dreq_addr) + int'(DATA_BASE));
      nxt.wd    = dreq_wdata;
      s1        = nxt;
      streak    = (gi || !ireq_valid) ? 0 : streak + (gd ? 1 : 0);
      pend      = ireq_valid && !gi;
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive_idle();
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    #2;
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_half();
    test_errors();
    test_arbitration();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
